// File: rtl/fixed_point_pkg.sv
// rtl/fixed_point_pkg.sv - shared sign-magnitude Q-format constants and helpers
package fixed_point_pkg;

  localparam int DEFAULT_Q = 8;
  localparam int DEFAULT_N = 16;

  // All-ones magnitude for an n-bit sign-magnitude word, zero-extended to 64 bits.
  function automatic logic [63:0] sm_sat_max(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  // Magnitude-only test, so +0 and -0 both count as zero.
  function automatic logic sm_is_zero(input logic [63:0] mag);
    return mag == 64'd0;
  endfunction

endpackage

// File: rtl/fixed_point_adder_pipe_if.sv
// rtl/fixed_point_adder_pipe_if.sv - operand/result stream bundle for the pipelined adder
interface fixed_point_adder_pipe_if #(
  parameter int N = fixed_point_pkg::DEFAULT_N
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] c;
  logic         ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, c, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, c, ovf
  );
endinterface

// File: rtl/fixed_point_sm_core.sv
// rtl/fixed_point_sm_core.sv - combinational magnitude add/subtract with saturation and +0 forcing
module fixed_point_sm_core
  import fixed_point_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-2:0] big_mag,
  input  logic [N-2:0] small_mag,
  input  logic         eq_sign,
  input  logic         sign_big,
  output logic         sign,
  output logic [N-2:0] mag,
  output logic         ovf
);

  localparam logic [63:0]  SAT_WIDE = sm_sat_max(N);
  localparam logic [N-2:0] SAT      = SAT_WIDE[N-2:0];

  logic [N-1:0] sum;
  logic [N-2:0] diff;

  always_comb begin
    sum  = {1'b0, big_mag} + {1'b0, small_mag};
    // big_mag >= small_mag is guaranteed by the S1 swap, so this never wraps
    diff = big_mag - small_mag;
    ovf  = eq_sign & sum[N-1];
    if (eq_sign) begin
      mag = sum[N-1] ? SAT : sum[N-2:0];
    end else begin
      mag = diff;
    end
    // When signs agree sign_big equals either operand's sign
    sign = sm_is_zero(64'(mag)) ? 1'b0 : sign_big;
  end

endmodule

// File: rtl/fixed_point_adder_pipe.sv
// rtl/fixed_point_adder_pipe.sv - two-stage saturating sign-magnitude adder with valid/ready flow
module fixed_point_adder_pipe
  import fixed_point_pkg::*;
#(
  parameter int Q = DEFAULT_Q,
  parameter int N = DEFAULT_N
) (
  input logic                      clk,
  input logic                      rst,
  fixed_point_adder_pipe_if.slave  bus
);

  if (N <= Q + 1) begin : g_bad_cfg
    $error("fixed_point_adder_pipe: N must exceed Q+1");
  end

  logic         s1_valid;
  logic         s1_eq_sign;
  logic         s1_sign_big;
  logic [N-2:0] s1_big;
  logic [N-2:0] s1_small;

  logic         s2_valid;
  logic [N-1:0] c_q;
  logic         ovf_q;

  logic         s1_adv;
  logic         s2_adv;
  logic [N-2:0] ma;
  logic [N-2:0] mb;
  logic         swap;

  logic         core_sign;
  logic [N-2:0] core_mag;
  logic         core_ovf;

  assign ma   = bus.a[N-2:0];
  assign mb   = bus.b[N-2:0];
  assign swap = mb > ma;

  assign s2_adv = !s2_valid || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.c         = c_q;
  assign bus.ovf       = ovf_q;

  fixed_point_sm_core #(.N(N)) u_core (
    .big_mag   (s1_big),
    .small_mag (s1_small),
    .eq_sign   (s1_eq_sign),
    .sign_big  (s1_sign_big),
    .sign      (core_sign),
    .mag       (core_mag),
    .ovf       (core_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_eq_sign  <= 1'b0;
      s1_sign_big <= 1'b0;
      s1_big      <= '0;
      s1_small    <= '0;
      s2_valid    <= 1'b0;
      c_q         <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_eq_sign  <= bus.a[N-1] == bus.b[N-1];
          s1_sign_big <= swap ? bus.b[N-1] : bus.a[N-1];
          s1_big      <= swap ? mb : ma;
          s1_small    <= swap ? ma : mb;
        end
      end
      // Output register only moves on a downstream take or into an empty slot
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          c_q   <= {core_sign, core_mag};
          ovf_q <= core_ovf;
        end
      end
    end
  end

endmodule

// File: doc/fixed_point_adder_pipe.md
# fixed_point_adder_pipe

Pipelined sign-magnitude fixed-point adder, the companion to the team's fixed-point subtractor: same number format, opposite operation, plus a streaming valid/ready interface. It accepts one operand pair per cycle and returns c = a + b two cycles later. Results saturate instead of wrapping, and a zero result is always +0. It sits in the datapath wherever Q-format sums are produced under backpressure (accumulators, filter taps).

## Interface
- Q, 8: fraction bits.
- N, 16: total word width. Bit N-1 is the sign; bits N-2:0 are the magnitude (N-1-Q integer bits, Q fraction bits). Requires N > Q+1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts the pair this cycle.
- a  input  N  operand A, sign-magnitude.
- b  input  N  operand B, sign-magnitude.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- c  output  N  sum, sign-magnitude.
- ovf  output  1  saturation occurred; qualified by out_valid.

## Operation
- ma = a[N-2:0], mb = b[N-2:0], sa = a[N-1], sb = b[N-1]. An input of -0 (sign set, magnitude 0) is treated as zero.
- **Stage 1 (S1), registered:**
  - eq_sign = (sa == sb).
  - swap = (mb > ma).
  - Stores big = max(ma, mb), small = min(ma, mb), sign_big = swap ? sb : sa, and sa.
- **Stage 2 (S2), registered:**
  - If eq_sign: sum = big + small at N bits. If sum[N-1] is set, the magnitude is all ones (2^(N-1)-1) and ovf = 1. Sign = sa.
  - Otherwise: magnitude = big - small, which never underflows; ovf = 0; sign = sign_big.
  - If the final magnitude is 0, the sign is forced to 0.
  - c = {sign, magnitude}.
- **Pipeline control:**
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv.
  - Transfers occur on valid && ready at each boundary.
  - Stages hold their contents when not advancing. Bubbles collapse.
  - Results leave in order of acceptance. Nothing is dropped or duplicated.

## Timing
- Latency: 2 cycles from input handshake to out_valid when out_ready is held high.
- Throughput: 1 result per cycle.
- Reset values: out_valid = 0, c = 0, ovf = 0. All internal stage valids are 0.
- in_ready is combinational from out_ready and the stage valids. It reads 1 while rst is held (pipeline empty), but inputs presented during rst are discarded.
- Reset mid-operation: both stages are flushed at the next edge. Results in flight are lost and out_valid = 0 the following cycle.
- While out_valid = 1 and out_ready = 0, c and ovf stay stable until the handshake completes.
- Simultaneous events: if the output is taken and a new input is presented in the same cycle with both stages full, all three transfers happen in that cycle. There is no bubble.

## Structure
- Package fixed_point_pkg holds:
  - Default Q and N.
  - A function sm_is_zero(x).
  - A function sm_sat_max(n) returning the all-ones magnitude.
  - The subtractor reuses the same package.
- One combinational sub-module, fixed_point_sm_core: it takes big, small, eq_sign and sign_big and returns {sign, magnitude, ovf}. S2 instantiates it.
- Pipeline registers and handshake logic live in the top module.

## Test plan
All cases use Q=8, N=16.
- **Like signs:** a=0x0180, b=0x0240 -> c=0x03C0, ovf=0, two cycles after acceptance.
- **Mixed signs, |b| > |a|:** a=0x0180, b=0x8240 -> c=0x80C0. Swapping a and b gives the same result.
- **Cancellation and zeros:**
  - a=0x0100, b=0x8100 -> c=0x0000.
  - a=0x8000, b=0x0000 -> c=0x0000. Never 0x8000.
- **Saturation:**
  - a=0x7F00, b=0x0200 -> c=0x7FFF, ovf=1.
  - a=0xFF00, b=0x8200 -> c=0xFFFF, ovf=1.
- **Backpressure:** stream 6 pairs back-to-back and hold out_ready=0 for 5 cycles starting at cycle 3.
  - in_ready drops after 2 pairs are buffered.
  - c holds stable while stalled.
  - All 6 results emerge in order, with no loss or duplication.
  - Full throughput returns once out_ready goes high.
- **Reset mid-operation:** pulse rst for 1 cycle with both stages valid.
  - out_valid = 0 on the next cycle.
  - The next accepted pair's result appears exactly 2 cycles after its handshake.
